xout_accum: RTL and testbench



---
 rtl/xacc_pkg.sv | 12 +
 rtl/xacc_fifo.sv | 56 +++++
 rtl/xout_accum.sv | 73 +++++++
 tb/tb_xout_accum.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/xacc_pkg.sv
// xacc_pkg: width helpers shared by xout_accum and its FIFO.
// XOUT_ACCUM_AVG_EN narrows the output width to NBITS for the averaging build.
package xacc_pkg;
    let SUM_BITS(NB, W) = NB + $clog2(W);
    let OUT_BITS(NB, W) =
`ifdef XOUT_ACCUM_AVG_EN
        NB;
`else
        NB + $clog2(W);
`endif
    let IS_POW2(N) = (N >= 2) && ((N & (N - 1)) == 0);
endpackage

// File: rtl/xacc_fifo.sv
// xacc_fifo: synchronous FIFO; a push onto a full FIFO is taken only alongside a pop.
module xacc_fifo
    import xacc_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    if (!IS_POW2(DEPTH)) $error("xacc_fifo: DEPTH must be a power of two >= 2");

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign count = cnt_q;
    assign head  = mem_q[rd_q];

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = din;
        rd_d  = do_pop  ? rd_q + 1'b1 : rd_q;
        wr_d  = do_push ? wr_q + 1'b1 : wr_q;
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/xout_accum.sv
// xout_accum: sums every WINDOW valid XIN samples and queues the sums behind a valid/ready port.
// XOUT_ACCUM_AVG_EN pushes the truncating mean (sum >> log2(WINDOW)) instead of the sum.
module xout_accum
    import xacc_pkg::*;
#(
    parameter int NBITS  = 8,
    parameter int WINDOW = 4,
    parameter int DEPTH  = 4,
    localparam int SBITS = OUT_BITS(NBITS, WINDOW)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [NBITS-1:0]       XIN,
    input  logic                   XVALID,
    output logic [SBITS-1:0]       SUM,
    output logic                   SVALID,
    input  logic                   SREADY,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   OVERFLOW
);
    localparam int AB = SUM_BITS(NBITS, WINDOW);
    localparam int IW = $clog2(WINDOW);

    if (!IS_POW2(WINDOW)) $error("xout_accum: WINDOW must be a power of two >= 2");

    logic [AB-1:0]    acc_q, acc_d, res;
    logic [IW-1:0]    idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic             done, pop, full, empty;
    logic [SBITS-1:0] push_val;

    always_comb begin
        res   = acc_q + AB'(XIN);
        done  = XVALID && (&idx_q);
        pop   = SVALID && SREADY;
        acc_d = XVALID ? (done ? '0 : res) : acc_q;
        // idx wraps to 0 on its own because WINDOW is a power of two
        idx_d = XVALID ? idx_q + 1'b1 : idx_q;
        ovf_d = ovf_q || (done && full && !pop);
`ifdef XOUT_ACCUM_AVG_EN
        push_val = res[AB-1:IW];
`else
        push_val = res;
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            acc_q <= '0;
            idx_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            idx_q <= idx_d;
            ovf_q <= ovf_d;
        end
    end

    xacc_fifo #(.WIDTH(SBITS), .DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (done),
        .pop   (SREADY),
        .din   (push_val),
        .head  (SUM),
        .count (COUNT),
        .full  (full),
        .empty (empty)
    );

    assign SVALID   = !empty;
    assign OVERFLOW = ovf_q;
endmodule

// File: tb/tb_xout_accum.sv
// tb_xout_accum: directed and randomized checks of xout_accum against a queue-based window/FIFO model.
module tb_xout_accum;
    localparam int NBITS  = 8;
    localparam int WINDOW = 4;
    localparam int DEPTH  = 4;
`ifdef XOUT_ACCUM_AVG_EN
    localparam int SH = $clog2(WINDOW);
`else
    localparam int SH = 0;
`endif
    localparam int SBITS = NBITS + $clog2(WINDOW) - SH;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic [NBITS-1:0] XIN = '0;
    logic             XVALID = 1'b0;
    logic             SREADY = 1'b0;
    logic [SBITS-1:0] SUM;
    logic             SVALID;
    logic [2:0]       COUNT;
    logic             OVERFLOW;

    int vectors = 0;
    int errors  = 0;
    int exp_q[$];
    int win[$];
    bit exp_ovf = 1'b0;

    xout_accum #(.NBITS(NBITS), .WINDOW(WINDOW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .XIN(XIN), .XVALID(XVALID), .SUM(SUM),
        .SVALID(SVALID), .SREADY(SREADY), .COUNT(COUNT), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    // Drives one cycle of inputs, advances the model by the same cycle, then samples 1ns after the edge.
    task automatic tick(input bit r, input bit v, input int x, input bit s);
        int  sum;
        bit  pop, done, full;
        RST_N = r; XVALID = v; XIN = 8'(x); SREADY = s;
        if (!r) begin
            exp_q.delete(); win.delete(); exp_ovf = 1'b0;
        end else begin
            pop  = exp_q.size() > 0 && s;
            full = exp_q.size() == DEPTH;
            done = v && win.size() == WINDOW - 1;
            sum  = x;
            if (done) begin
                foreach (win[i]) sum += win[i];
                win.delete();
            end else if (v) win.push_back(x);
            if (pop) void'(exp_q.pop_front());
            if (done) begin
                if (full && !pop) exp_ovf = 1'b1;
                else exp_q.push_back(sum >> SH);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            vectors++;
            if ({SVALID, SUM, COUNT, OVERFLOW} !== '0) begin
                errors++;
                $display("FAIL reset cyc=%0d got svalid=%0b sum=%0d count=%0d ovf=%0b, want all 0", i, SVALID, SUM, COUNT, OVERFLOW);
            end
        end
    endtask

    task automatic test_basic();
        int xs[4] = '{10, 20, 30, 40};
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, xs[i], 1'b1);
            vectors++;
            if (SVALID !== (i == 3)) begin
                errors++;
                $display("FAIL basic_svalid sample=%0d got=%0b want=%0b", i, SVALID, i == 3);
            end
        end
        vectors++;
        if (SUM !== SBITS'(100 >> SH)) begin
            errors++;
            $display("FAIL basic_sum got=%0d want=%0d", SUM, 100 >> SH);
        end
        tick(1'b1, 1'b0, 0, 1'b1);
        vectors++;
        if (SVALID !== 1'b0 || COUNT !== 3'd0) begin
            errors++;
            $display("FAIL basic_drain got svalid=%0b count=%0d want 0/0", SVALID, COUNT);
        end
    endtask

    task automatic test_gaps_max();
        int gv[6] = '{1, 0, 1, 0, 1, 1};
        int gx[6] = '{1, 99, 2, 77, 3, 4};
        for (int i = 0; i < 6; i++) tick(1'b1, gv[i][0], gx[i], 1'b0);
        vectors++;
        if (SVALID !== 1'b1 || COUNT !== 3'd1 || SUM !== SBITS'(10 >> SH)) begin
            errors++;
            $display("FAIL gaps got svalid=%0b count=%0d sum=%0d want 1/1/%0d", SVALID, COUNT, SUM, 10 >> SH);
        end
        tick(1'b1, 1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 255, 1'b0);
        vectors++;
        if (SVALID !== 1'b1 || SUM !== SBITS'(1020 >> SH)) begin
            errors++;
            $display("FAIL max_sum got svalid=%0b sum=%0d want 1/%0d", SVALID, SUM, 1020 >> SH);
        end
        tick(1'b1, 1'b0, 0, 1'b1);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b1, 1, 1'b0);
            if (i == 15 || i == 19) begin
                vectors++;
                if (COUNT !== 3'd4 || OVERFLOW !== (i == 19)) begin
                    errors++;
                    $display("FAIL ovf_fill window=%0d got count=%0d ovf=%0b want 4/%0b", i / 4 + 1, COUNT, OVERFLOW, i == 19);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (SVALID !== 1'b1 || SUM !== SBITS'(4 >> SH)) begin
                errors++;
                $display("FAIL ovf_pop n=%0d got svalid=%0b sum=%0d want 1/%0d", i, SVALID, SUM, 4 >> SH);
            end
            tick(1'b1, 1'b0, 0, 1'b1);
        end
        vectors++;
        if (SVALID !== 1'b0 || OVERFLOW !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after got svalid=%0b ovf=%0b want 0/1", SVALID, OVERFLOW);
        end
    endtask

    task automatic test_full_pop();
        int s = 0;
        int x;
        tick(1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 16; i++) tick(1'b1, 1'b1, int'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 4; i++) begin
            x = int'($urandom_range(0, 255));
            s += x;
            tick(1'b1, 1'b1, x, i == 3);
        end
        vectors++;
        if (COUNT !== 3'd4 || OVERFLOW !== 1'b0) begin
            errors++;
            $display("FAIL fullpop got count=%0d ovf=%0b want 4/0", COUNT, OVERFLOW);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (SVALID !== 1'b1 || SUM !== SBITS'(exp_q[0])) begin
                errors++;
                $display("FAIL fullpop_drain n=%0d got svalid=%0b sum=%0d want 1/%0d", i, SVALID, SUM, exp_q[0]);
            end
            if (i == 3) begin
                vectors++;
                if (SUM !== SBITS'(s >> SH)) begin
                    errors++;
                    $display("FAIL fullpop_tail got=%0d want=%0d", SUM, s >> SH);
                end
            end
            tick(1'b1, 1'b0, 0, 1'b1);
        end
    endtask

    task automatic test_mid_reset();
        tick(1'b1, 1'b1, 50, 1'b0);
        tick(1'b1, 1'b1, 50, 1'b0);
        tick(1'b0, 1'b1, 50, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1, 1'b0);
        vectors++;
        if (COUNT !== 3'd1 || SUM !== SBITS'(4 >> SH)) begin
            errors++;
            $display("FAIL midreset got count=%0d sum=%0d want 1/%0d", COUNT, SUM, 4 >> SH);
        end
        tick(1'b1, 1'b0, 0, 1'b1);
        vectors++;
        if (SVALID !== 1'b0) begin
            errors++;
            $display("FAIL midreset_drain got svalid=%0b want 0", SVALID);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 59) != 0), 1'($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 255)), 1'($urandom_range(0, 2) == 0));
            vectors++;
            if (SVALID !== (exp_q.size() > 0) || COUNT !== 3'(exp_q.size()) || OVERFLOW !== exp_ovf ||
                (exp_q.size() > 0 && SUM !== SBITS'(exp_q[0]))) begin
                errors++;
                $display("FAIL random cyc=%0d got svalid=%0b count=%0d ovf=%0b sum=%0d want count=%0d ovf=%0b sum=%0d",
                         i, SVALID, COUNT, OVERFLOW, SUM, exp_q.size(), exp_ovf, exp_q.size() > 0 ? exp_q[0] : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps_max();
        test_overflow();
        test_full_pop();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
